// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers: control-word layout,
// per-stage payload widths and the counter saturation helper.
// No logic; imported by pipe_stage_reg and pipe_sat_cnt.
package pipe_pkg;

    // Control word layout, LSB first
    localparam int CTRL_W     = 16;
    localparam int REGWRITE_B = 0;
    localparam int MEMWRITE_B = 1;
    localparam int MEMREAD_B  = 2;
    localparam int WDSEL_LSB  = 3;
    localparam int WDSEL_W    = 2;
    localparam int ALUSRC_B   = 5;
    localparam int ALUOP_LSB  = 6;
    localparam int ALUOP_W    = 4;
    localparam int NPCOP_LSB  = 10;
    localparam int NPCOP_W    = 3;
    localparam int DMTYPE_LSB = 13;
    localparam int DMTYPE_W   = 3;

    // Payload widths used by the instantiating stages
    localparam int XLEN          = 32;
    localparam int RADDR_W       = 5;
    localparam int DATA_W_DEF    = 128;
    localparam int IF_ID_DATA_W  = 2 * XLEN;                // PC, PC+4
    localparam int ID_EX_DATA_W  = 5 * XLEN + RADDR_W;      // PC, PC+4, RD1, RD2, Imm, rd
    localparam int EX_MEM_DATA_W = 3 * XLEN + RADDR_W;      // PC+4, ALU, RD2, rd
    localparam int MEM_WB_DATA_W = 3 * XLEN + RADDR_W;      // PC+4, ALU, RDATA, rd

    // All-ones value a w-bit counter saturates at (w <= 63)
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter: adds inc (0..3) each cycle, sticks at all-ones.
// Latency: count visible the cycle after the increment. No backpressure.
// Ports: clk, reset (sync, active-high), inc[1:0], cnt[W-1:0].
module pipe_sat_cnt
    import pipe_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] SAT = W'(sat_max(W));

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   sum;

    // inc never exceeds 3, so the carry bit alone detects overflow
    always_comb begin
        sum   = {1'b0, cnt_q} + (W+1)'(inc);
        cnt_d = sum[W] ? SAT : sum[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready, stall hold, flush kill.
// Latency: 1 cycle. Backpressure: SKID=0 combinational o_ready, SKID=1 registered
// o_ready from a second (skid) entry. Ports: upstream i_valid/o_ready/i_data/i_ctrl,
// downstream o_valid/i_ready/o_data/o_ctrl, i_stall, flush, two saturating counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic              i_stall,
    input  logic              flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    logic              rdy, accept, drain;
    logic              main_vld_q, main_vld_d;
    logic [DATA_W-1:0] main_dat_q, main_dat_d;
    logic [CTRL_W-1:0] main_ctl_q, main_ctl_d;
    logic              skid_vld_q;
    logic [DATA_W-1:0] skid_dat_q;
    logic [CTRL_W-1:0] skid_ctl_q;
    logic [1:0]        stall_inc, flush_inc;

    assign accept = i_valid & rdy;
    // A stall freezes the output, so nothing leaves even if downstream is ready
    assign drain  = main_vld_q & i_ready & ~i_stall;

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_vld_d;
            logic [DATA_W-1:0] skid_dat_d;
            logic [CTRL_W-1:0] skid_ctl_d;

            assign rdy = ~reset & ~skid_vld_q & ~i_stall;

            always_comb begin
                skid_vld_d = skid_vld_q;
                skid_dat_d = skid_dat_q;
                skid_ctl_d = skid_ctl_q;
                if (flush) begin
                    skid_vld_d = 1'b0;
                    skid_ctl_d = '0;
                end else if (!i_stall) begin
                    if (drain && skid_vld_q) begin
                        // skid word moves into main; rdy was low so no accept
                        skid_vld_d = 1'b0;
                        skid_ctl_d = '0;
                    end else if (accept && main_vld_q && !drain) begin
                        skid_vld_d = 1'b1;
                        skid_dat_d = i_data;
                        skid_ctl_d = i_ctrl;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    skid_vld_q <= 1'b0;
                    skid_dat_q <= '0;
                    skid_ctl_q <= '0;
                end else begin
                    skid_vld_q <= skid_vld_d;
                    skid_dat_q <= skid_dat_d;
                    skid_ctl_q <= skid_ctl_d;
                end
            end
        end else begin : g_noskid
            assign rdy        = ~reset & ~i_stall & (~main_vld_q | i_ready);
            assign skid_vld_q = 1'b0;
            assign skid_dat_q = '0;
            assign skid_ctl_q = '0;
        end
    endgenerate

    always_comb begin
        main_vld_d = main_vld_q;
        main_dat_d = main_dat_q;
        main_ctl_d = main_ctl_q;
        if (flush) begin
            main_vld_d = 1'b0;
            main_ctl_d = '0;
        end else if (!i_stall) begin
            if (drain) begin
                if (skid_vld_q) begin
                    main_dat_d = skid_dat_q;
                    main_ctl_d = skid_ctl_q;
                end else if (accept) begin
                    main_dat_d = i_data;
                    main_ctl_d = i_ctrl;
                end else begin
                    main_vld_d = 1'b0;
                    main_ctl_d = '0;
                end
            end else if (accept && !main_vld_q) begin
                main_vld_d = 1'b1;
                main_dat_d = i_data;
                main_ctl_d = i_ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_vld_q <= 1'b0;
            main_dat_q <= '0;
            main_ctl_q <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            main_dat_q <= main_dat_d;
            main_ctl_q <= main_ctl_d;
        end
    end

    // Back-pressure cycle: holding a valid word that does not leave (flush excluded)
    assign stall_inc = {1'b0, main_vld_q & ~flush & (i_stall | ~i_ready)};
    assign flush_inc = flush ? ({1'b0, main_vld_q} + {1'b0, skid_vld_q}) : 2'b00;

    pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .cnt   (o_stall_cnt)
    );

    pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .cnt   (o_flush_cnt)
    );

    assign o_ready = rdy;
    assign o_valid = main_vld_q;
    assign o_data  = main_dat_q;
    // Bubbles must never carry live RegWrite/MemWrite bits
    assign o_ctrl  = main_vld_q ? main_ctl_q : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 instance and one SKID=1 / CNT_W=4 instance
// share stimulus; sel picks whose output the scoreboard monitor watches.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         reset, i_valid, i_stall, flush, i_ready, sel;
    logic [127:0] i_data;
    logic [15:0]  i_ctrl;

    logic         a_o_ready, a_o_valid, b_o_ready, b_o_valid;
    logic [127:0] a_o_data, b_o_data;
    logic [15:0]  a_o_ctrl, b_o_ctrl, a_stall, a_flush;
    logic [3:0]   b_stall, b_flush;

    logic         m_o_valid;
    logic [127:0] m_o_data;
    logic [15:0]  m_o_ctrl;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  c;
        int           due;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(16), .SKID(0), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(a_o_ready),
        .i_data(i_data), .i_ctrl(i_ctrl), .i_stall(i_stall), .flush(flush),
        .o_valid(a_o_valid), .i_ready(i_ready), .o_data(a_o_data), .o_ctrl(a_o_ctrl),
        .o_stall_cnt(a_stall), .o_flush_cnt(a_flush)
    );

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(16), .SKID(1), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(b_o_ready),
        .i_data(i_data), .i_ctrl(i_ctrl), .i_stall(i_stall), .flush(flush),
        .o_valid(b_o_valid), .i_ready(i_ready), .o_data(b_o_data), .o_ctrl(b_o_ctrl),
        .o_stall_cnt(b_stall), .o_flush_cnt(b_flush)
    );

    assign m_o_valid = sel ? b_o_valid : a_o_valid;
    assign m_o_data  = sel ? b_o_data  : a_o_data;
    assign m_o_ctrl  = sel ? b_o_ctrl  : a_o_ctrl;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] d, input logic [15:0] c);
        i_valid = v;
        i_data  = d;
        i_ctrl  = c;
    endtask

    task automatic push(input logic [127:0] d, input logic [15:0] c, input int due);
        exp_t e;
        e.d   = d;
        e.c   = c;
        e.due = due;
        sb.push_back(e);
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        drive(1'b0, '0, '0);
        nxt;
        nxt;
        reset = 1'b0;
    endtask

    // Monitor: every drain pops one expected word; bubbles must show ctrl 0
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            if (m_o_valid && i_ready && !i_stall && !flush) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL drain_unexpected: got data %0h, expected no output", m_o_data);
                end else begin
                    e = sb.pop_front();
                    chk("drain_data", m_o_data, e.d);
                    chk("drain_ctrl", {112'b0, m_o_ctrl}, {112'b0, e.c});
                    if (e.due >= 0) chk("drain_latency", cyc, e.due);
                end
            end
            if (!m_o_valid) chk("bubble_ctrl", {112'b0, m_o_ctrl}, 128'h0);
        end
    end

    initial begin
        sel     = 1'b0;
        reset   = 1'b1;
        i_stall = 1'b0;
        flush   = 1'b0;
        i_ready = 1'b0;
        drive(1'b1, {4{32'hAAAA_AAAA}}, 16'hAAAA);

        // Reset overrides a valid upstream word
        nxt;
        @(negedge clk);
        chk("rst_ready_a", a_o_ready, 0);
        chk("rst_ready_b", b_o_ready, 0);
        nxt;
        reset = 1'b0;
        drive(1'b0, '0, '0);
        @(negedge clk);
        chk("rst_valid_a", a_o_valid, 0);
        chk("rst_ctrl_a", a_o_ctrl, 0);
        chk("rst_data_a", a_o_data, 0);
        chk("rst_stall_a", a_stall, 0);
        chk("rst_flush_a", a_flush, 0);
        chk("rst_valid_b", b_o_valid, 0);
        chk("rst_data_b", b_o_data, 0);
        chk("rst_cnt_b", {b_stall, b_flush}, 0);

        // SKID=0 streaming: each word out exactly one cycle after accept
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            nxt;
            drive(1'b1, 128'(k), 16'(k));
            push(128'(k), 16'(k), cyc + 1);
            @(negedge clk);
            chk("stream_ready", a_o_ready, 1);
        end
        nxt;
        drive(1'b0, '0, '0);
        nxt;
        nxt;

        // SKID=0 stall hold for two cycles with downstream ready
        drive(1'b1, 128'h55, 16'h0055);
        push(128'h55, 16'h0055, -1);
        @(negedge clk);
        chk("stall_load_ready", a_o_ready, 1);
        for (int k = 0; k < 2; k++) begin
            nxt;
            drive(1'b0, '0, '0);
            i_stall = 1'b1;
            @(negedge clk);
            chk("stall_ready", a_o_ready, 0);
            chk("stall_valid", a_o_valid, 1);
            chk("stall_data", a_o_data, 128'h55);
            chk("stall_ctrl", a_o_ctrl, 16'h0055);
        end
        nxt;
        i_stall = 1'b0;
        @(negedge clk);
        chk("stall_cnt", a_stall, 2);

        // Flush during stall kills the held word and discards the offered one
        nxt;
        drive(1'b1, 128'h66, 16'h0066);
        push(128'h66, 16'h0066, -1);
        @(negedge clk);
        nxt;
        drive(1'b1, 128'h77, 16'h0077);
        i_stall = 1'b1;
        flush   = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        chk("flush_pre_valid", a_o_valid, 1);
        nxt;
        i_stall = 1'b0;
        flush   = 1'b0;
        drive(1'b0, '0, '0);
        @(negedge clk);
        chk("flush_valid_a", a_o_valid, 0);
        chk("flush_ctrl_a", a_o_ctrl, 0);
        chk("flush_cnt_a", a_flush, 1);

        // Switch to the SKID=1, CNT_W=4 instance
        nxt;
        sel = 1'b1;
        pulse_reset;

        // Two words under back-pressure: second lands in the skid entry
        i_ready = 1'b0;
        drive(1'b1, 128'h11, 16'h0011);
        push(128'h11, 16'h0011, -1);
        @(negedge clk);
        chk("skid_ready_0", b_o_ready, 1);
        nxt;
        drive(1'b1, 128'h22, 16'h0022);
        push(128'h22, 16'h0022, -1);
        @(negedge clk);
        chk("skid_ready_1", b_o_ready, 1);
        nxt;
        drive(1'b0, '0, '0);
        @(negedge clk);
        chk("skid_full_ready", b_o_ready, 0);
        chk("skid_head_data", b_o_data, 128'h11);
        nxt;
        nxt;
        i_ready = 1'b1;
        @(negedge clk);
        chk("skid_stall_cnt", b_stall, 3);
        chk("skid_drain_ready", b_o_ready, 0);
        nxt;
        @(negedge clk);
        chk("skid_empty_ready", b_o_ready, 1);
        nxt;
        i_ready = 1'b0;
        @(negedge clk);
        chk("skid_idle_valid", b_o_valid, 0);

        // Both entries full, flush with a valid upstream word
        nxt;
        drive(1'b1, 128'h33, 16'h0033);
        push(128'h33, 16'h0033, -1);
        @(negedge clk);
        nxt;
        drive(1'b1, 128'h44, 16'h0044);
        push(128'h44, 16'h0044, -1);
        @(negedge clk);
        nxt;
        drive(1'b1, 128'h77, 16'h0077);
        flush = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("flush_full_ready", b_o_ready, 0);
        nxt;
        flush = 1'b0;
        drive(1'b0, '0, '0);
        @(negedge clk);
        chk("flush2_valid", b_o_valid, 0);
        chk("flush2_ctrl", b_o_ctrl, 0);
        chk("flush2_cnt", b_flush, 2);
        chk("flush2_ready", b_o_ready, 1);

        // 4-bit stall counter under 20 back-pressure cycles
        nxt;
        pulse_reset;
        drive(1'b1, 128'h99, 16'h0099);
        push(128'h99, 16'h0099, -1);
        @(negedge clk);
        nxt;
        drive(1'b0, '0, '0);
        repeat (14) nxt;
        @(negedge clk);
        chk("sat_cnt_14", b_stall, 4'hE);
        repeat (6) nxt;
        @(negedge clk);
        chk("sat_cnt_hold", b_stall, 4'hF);
        nxt;
        i_ready = 1'b1;
        @(negedge clk);
        nxt;
        i_ready = 1'b0;
        nxt;
        @(negedge clk);
        chk("sb_empty", 128'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic parametrised pipeline stage register. It is the successor to the fixed per-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries one payload word plus one control word. It adds a ready/valid handshake, hazard stall hold, flush with control kill, an optional skid buffer for registered back-pressure, and saturating performance counters. It is instantiated between every pair of pipeline stages.

Parameters:
DATA_W, 128, payload width (PC, PC+4, RD1, RD2, Imm, rd concatenated by the instantiating stage)
CTRL_W, 16, control width (RegWrite, MemWrite, MemRead, WDSel, ALUSrc, ALUOp, NPCOp, DMType, ...)
SKID, 0, 0 = single entry with combinational o_ready; 1 = two entries with registered o_ready
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
i_valid  in  1  upstream holds a valid instruction
o_ready  out  1  stage can accept this cycle
i_data  in  DATA_W  upstream payload
i_ctrl  in  CTRL_W  upstream control word
i_stall  in  1  hazard-unit hold; freezes stage contents
flush  in  1  kill all held instructions (branch/jump redirect)
o_valid  out  1  output holds a valid instruction
i_ready  in  1  downstream accepts this cycle
o_data  out  DATA_W  payload to next stage
o_ctrl  out  CTRL_W  control to next stage; all-zero whenever o_valid=0
o_stall_cnt  out  CNT_W  saturating count of back-pressure cycles
o_flush_cnt  out  CNT_W  saturating count of killed valid entries

Behaviour:
- Reset (synchronous, active-high): main and skid valid=0, o_data=0, o_ctrl=0, both counters=0, o_ready=0 during the reset cycle. Reset overrides every other input.
- Handshake terms: accept = i_valid & o_ready; drain = o_valid & i_ready. Data must not be lost or duplicated.
- Priority per cycle: reset > flush > i_stall > handshake.
- flush:
  - Next cycle: all entries invalid and o_ctrl=0.
  - o_data is held, but its value is don't-care.
  - Any accept in the same cycle is discarded.
  - o_flush_cnt += number of valid entries killed (0, 1 or 2), saturating.
- i_stall=1 (and no flush):
  - o_ready=0; contents and o_valid held; the drain is suppressed.
  - o_stall_cnt += 1 when o_valid=1.
- SKID=0:
  - o_ready = ~i_stall & (~o_valid | i_ready). This is combinational; latency is 1 cycle.
  - On accept, the register loads i_data/i_ctrl and o_valid=1.
  - On drain without accept, o_valid=0 and o_ctrl=0.
- SKID=1:
  - o_ready = ~skid_valid & ~i_stall, with skid_valid registered.
  - Accept while main is full and not draining: the word goes to the skid entry and o_ready drops next cycle.
  - Drain while skid is valid: skid moves to main; a simultaneous accept is impossible (o_ready=0).
  - Drain and accept with skid empty: main loads the new word.
  - Order is strictly FIFO; latency is 1 cycle when empty; max occupancy is 2.
- o_stall_cnt also increments when o_valid=1, i_ready=0 and i_stall=0.
- Counters saturate at all-ones and never wrap.
- o_ctrl is forced to 0 when o_valid=0, so downstream RegWrite/MemWrite can never fire from a bubble.
- Simultaneous i_stall with a downstream i_ready: the stall wins, no drain occurs and o_valid is held.

Decomposition:
- Shared package pipe_pkg holds:
  - CTRL_W and the control-word bit offsets and field widths (REGWRITE_B, MEMWRITE_B, MEMREAD_B, WDSEL_LSB/W, ALUSRC_B, ALUOP_LSB/W, NPCOP_LSB/W, DMTYPE_LSB/W).
  - Stage payload width constants.
  - The counter saturation constant.
- One sub-module: pipe_sat_cnt (CNT_W saturating incrementer with increment-amount input), instantiated twice.
- The skid logic is generated inline under SKID.

Test Plan:
- Reset with i_valid=1, i_data=0xAAAA.. asserted -> after release o_valid=0, o_ctrl=0, o_data=0, both counters=0.
- SKID=0, i_ready=1, stream of 4 words (data 1..4, ctrl 0x0001..0x0004) -> each appears exactly 1 cycle later, in order, o_ready=1 throughout.
- SKID=1, i_ready held 0 for 3 cycles while feeding words 0x11, 0x22 -> o_ready=0 after the second accept; o_stall_cnt=3; on i_ready=1 the output is 0x11 then 0x22 with no loss.
- SKID=1, both entries full, flush=1 with i_valid=1 -> next cycle o_valid=0, o_ctrl=0, o_flush_cnt=2, o_ready=1.
- i_stall=1 for 2 cycles with o_valid=1 and i_ready=1 -> o_data/o_ctrl held constant, o_ready=0, o_stall_cnt=2; flush during stall -> o_valid=0 next cycle.
- CNT_W=4, force 20 back-pressure cycles -> o_stall_cnt stops at 0xF and does not wrap.
